mc_rf_serial: RTL and testbench

//  Bit-serial register file for serv_top's RF interface; replaces the switch/light RF stand-ins on the
//  I/O harness. Holds NREG x 32-bit registers (32 GPRs + CSR slots) as flops.
//  - Reads: two registers streamed LSB-first, one bit per cycle.
//  - Writes: up to two streams per transaction, one bit per cycle.

---
 rtl/mc_rf_serial_if.sv | 29 ++
 rtl/mc_rf_serial.sv | 99 +++++++++
 tb/tb_mc_rf_serial.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mc_rf_serial_if.sv
// Bit-serial register-file bus: request/ack handshake plus two read and two write bit streams.
interface mc_rf_serial_if;
  logic       i_rf_rreq;
  logic       i_rf_wreq;
  logic       o_rf_ready;
  logic [5:0] i_rreg0;
  logic [5:0] i_rreg1;
  logic       o_rdata0;
  logic       o_rdata1;
  logic [5:0] i_wreg0;
  logic [5:0] i_wreg1;
  logic       i_wen0;
  logic       i_wen1;
  logic       i_wdata0;
  logic       i_wdata1;
  logic       o_busy;

  modport master (
    output i_rf_rreq, i_rf_wreq, i_rreg0, i_rreg1, i_wreg0, i_wreg1,
           i_wen0, i_wen1, i_wdata0, i_wdata1,
    input  o_rf_ready, o_rdata0, o_rdata1, o_busy
  );

  modport slave (
    input  i_rf_rreq, i_rf_wreq, i_rreg0, i_rreg1, i_wreg0, i_wreg1,
           i_wen0, i_wen1, i_wdata0, i_wdata1,
    output o_rf_ready, o_rdata0, o_rdata1, o_busy
  );
endinterface

// File: rtl/mc_rf_serial.sv
// Bit-serial flop register file: ready one cycle after a request, then W cycles of LSB-first streams.
// Requests to a busy FSM are dropped (no ready); the read and write FSMs run independently.
module mc_rf_serial #(
  parameter int NREG = 64,
  parameter int W    = 32
) (
  input logic          clk,
  input logic          i_rst,
  mc_rf_serial_if.slave rf
);
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, ACK, STREAM} state_t;

  state_t          rstate;
  state_t          wstate;
  logic [CW-1:0]   rcnt;
  logic [CW-1:0]   wcnt;
  logic [5:0]      ra0;
  logic [5:0]      ra1;
  logic [5:0]      wa0;
  logic [5:0]      wa1;
  logic            ready;
  logic [W-1:0]    regs [NREG];

  logic rd_acc;
  logic wr_acc;
  assign rd_acc = rf.i_rf_rreq && (rstate == IDLE);
  assign wr_acc = rf.i_rf_wreq && (wstate == IDLE);

  // Address 0 and anything past the array behave as a hardwired zero register.
  function automatic logic addr_ok(input logic [5:0] a);
    return (a != 6'd0) && (32'(a) < NREG);
  endfunction

  always_ff @(posedge clk) begin
    if (i_rst) begin
      rstate <= IDLE;
      wstate <= IDLE;
      rcnt   <= '0;
      wcnt   <= '0;
      ra0    <= '0;
      ra1    <= '0;
      wa0    <= '0;
      wa1    <= '0;
      ready  <= 1'b0;
    end else begin
      ready <= rd_acc || wr_acc;

      case (rstate)
        IDLE: if (rd_acc) begin
          rstate <= ACK;
          ra0    <= rf.i_rreg0;
          ra1    <= rf.i_rreg1;
        end
        ACK: begin
          rstate <= STREAM;
          rcnt   <= '0;
        end
        STREAM: begin
          rcnt <= rcnt + 1'b1;
          if (rcnt == CW'(W - 1)) rstate <= IDLE;
        end
        default: rstate <= IDLE;
      endcase

      case (wstate)
        IDLE: if (wr_acc) begin
          wstate <= ACK;
          wa0    <= rf.i_wreg0;
          wa1    <= rf.i_wreg1;
        end
        ACK: begin
          wstate <= STREAM;
          wcnt   <= '0;
        end
        STREAM: begin
          wcnt <= wcnt + 1'b1;
          if (wcnt == CW'(W - 1)) wstate <= IDLE;
        end
        default: wstate <= IDLE;
      endcase
    end
  end

  // Port 1 is assigned last so it wins a same-bit collision; reset blocks the in-flight bit.
  always_ff @(posedge clk) begin
    if (!i_rst && wstate == STREAM) begin
      if (rf.i_wen0 && addr_ok(wa0)) regs[wa0][wcnt] <= rf.i_wdata0;
      if (rf.i_wen1 && addr_ok(wa1)) regs[wa1][wcnt] <= rf.i_wdata1;
    end
  end

  // Read mux sees storage before this cycle's write commits, so a same-bit read gets the old value.
  assign rf.o_rdata0   = (rstate == STREAM && addr_ok(ra0)) ? regs[ra0][rcnt] : 1'b0;
  assign rf.o_rdata1   = (rstate == STREAM && addr_ok(ra1)) ? regs[ra1][rcnt] : 1'b0;
  assign rf.o_rf_ready = ready;
  assign rf.o_busy     = (rstate != IDLE) || (wstate != IDLE);
endmodule

// File: tb/tb_mc_rf_serial.sv
// Directed bench for mc_rf_serial: streams known words in and out and checks every observable.
module tb_mc_rf_serial;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mc_rf_serial_if rf();

  mc_rf_serial dut (
    .clk  (clk),
    .i_rst(rst),
    .rf   (rf)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rf.i_rf_rreq = 1'b0; rf.i_rf_wreq = 1'b0;
    rf.i_rreg0 = '0; rf.i_rreg1 = '0; rf.i_wreg0 = '0; rf.i_wreg1 = '0;
    rf.i_wen0 = 1'b0; rf.i_wen1 = 1'b0; rf.i_wdata0 = 1'b0; rf.i_wdata1 = 1'b0;
  endtask

  task automatic do_write(input logic [5:0] a0, input logic [31:0] d0, input logic [31:0] m0,
                          input logic [5:0] a1, input logic [31:0] d1, input logic [31:0] m1,
                          input string tag, input int abort_at);
    rf.i_rf_wreq = 1'b1; rf.i_wreg0 = a0; rf.i_wreg1 = a1;
    tick();
    rf.i_rf_wreq = 1'b0;
    chk({tag, "_wr_ready"}, 32'(rf.o_rf_ready), 32'd1);
    tick();
    for (int k = 0; k < 32; k++) begin
      rf.i_wen0 = m0[k]; rf.i_wdata0 = d0[k];
      rf.i_wen1 = m1[k]; rf.i_wdata1 = d1[k];
      if (k == abort_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk({tag, "_abort_busy"}, 32'(rf.o_busy), 32'd0);
        chk({tag, "_abort_ready"}, 32'(rf.o_rf_ready), 32'd0);
        break;
      end
      tick();
    end
    rf.i_wen0 = 1'b0; rf.i_wen1 = 1'b0; rf.i_wdata0 = 1'b0; rf.i_wdata1 = 1'b0;
  endtask

  task automatic do_read(input logic [5:0] a0, input logic [5:0] a1,
                         output logic [31:0] r0, output logic [31:0] r1,
                         input string tag, input int inject_at);
    r0 = '0; r1 = '0;
    rf.i_rf_rreq = 1'b1; rf.i_rreg0 = a0; rf.i_rreg1 = a1;
    tick();
    rf.i_rf_rreq = 1'b0;
    chk({tag, "_rd_ready"}, 32'(rf.o_rf_ready), 32'd1);
    tick();
    chk({tag, "_rd_ready_drop"}, 32'(rf.o_rf_ready), 32'd0);
    for (int k = 0; k < 32; k++) begin
      r0[k] = rf.o_rdata0;
      r1[k] = rf.o_rdata1;
      if (k == 5) chk({tag, "_busy_stream"}, 32'(rf.o_busy), 32'd1);
      if (k == inject_at + 1) chk({tag, "_ignored_rreq"}, 32'(rf.o_rf_ready), 32'd0);
      rf.i_rf_rreq = (k == inject_at);
      if (k == inject_at) rf.i_rreg0 = 6'd5;
      tick();
    end
    rf.i_rf_rreq = 1'b0;
    chk({tag, "_rdata_after"}, 32'(rf.o_rdata0), 32'd0);
    chk({tag, "_busy_after"}, 32'(rf.o_busy), 32'd0);
  endtask

  logic [31:0] r0, r1;
  logic [31:0] wd;

  initial begin
    rst = 1'b1;
    clear_inputs();
    tick(); tick();
    chk("rst_ready", 32'(rf.o_rf_ready), 32'd0);
    chk("rst_rdata0", 32'(rf.o_rdata0), 32'd0);
    chk("rst_rdata1", 32'(rf.o_rdata1), 32'd0);
    chk("rst_busy", 32'(rf.o_busy), 32'd0);
    rst = 1'b0;
    tick();

    // Basic write then read back
    do_write(6'd5, 32'hDEADBEEF, 32'hFFFFFFFF, 6'd0, 32'h0, 32'h0, "t1", -1);
    do_read(6'd5, 6'd0, r0, r1, "t1", -1);
    chk("t1_reg5", r0, 32'hDEADBEEF);
    chk("t1_rd1_reg0", r1, 32'h0);

    // Register 0 stays zero
    do_write(6'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, "t2", -1);
    do_read(6'd0, 6'd0, r0, r1, "t2", -1);
    chk("t2_rd0", r0, 32'h0);
    chk("t2_rd1", r1, 32'h0);

    // Concurrent read and write of the same register: read sees old contents
    do_write(6'd7, 32'h12345678, 32'hFFFFFFFF, 6'd0, 32'h0, 32'h0, "t3pre", -1);
    wd = 32'hA5A5A5A5;
    rf.i_rf_rreq = 1'b1; rf.i_rf_wreq = 1'b1;
    rf.i_rreg0 = 6'd7; rf.i_rreg1 = 6'd0; rf.i_wreg0 = 6'd7; rf.i_wreg1 = 6'd0;
    tick();
    rf.i_rf_rreq = 1'b0; rf.i_rf_wreq = 1'b0;
    chk("t3_ready", 32'(rf.o_rf_ready), 32'd1);
    tick();
    chk("t3_ready_single", 32'(rf.o_rf_ready), 32'd0);
    r0 = '0;
    for (int k = 0; k < 32; k++) begin
      rf.i_wen0 = 1'b1; rf.i_wdata0 = wd[k];
      r0[k] = rf.o_rdata0;
      tick();
    end
    rf.i_wen0 = 1'b0; rf.i_wdata0 = 1'b0;
    chk("t3_read_old", r0, 32'h12345678);
    chk("t3_busy_end", 32'(rf.o_busy), 32'd0);
    do_read(6'd7, 6'd5, r0, r1, "t3post", -1);
    chk("t3_read_new", r0, 32'hA5A5A5A5);
    chk("t3_reg5_kept", r1, 32'hDEADBEEF);

    // Dual write with partial enables on port 1
    do_write(6'd4, 32'h123456AB, 32'hFFFFFFFF, 6'd0, 32'h0, 32'h0, "t4pre", -1);
    do_write(6'd3, 32'h0000FFFF, 32'hFFFFFFFF, 6'd4, 32'hFFFF0000, 32'hFFFFFF00, "t4", -1);
    do_read(6'd3, 6'd4, r0, r1, "t4", -1);
    chk("t4_reg3", r0, 32'h0000FFFF);
    chk("t4_reg4", r1, 32'hFFFF00AB);

    // Both ports on one register: port 1 wins
    do_write(6'd9, 32'h00000000, 32'hFFFFFFFF, 6'd9, 32'h00000001, 32'hFFFFFFFF, "t5", -1);
    do_read(6'd9, 6'd3, r0, r1, "t5", -1);
    chk("t5_reg9", r0, 32'h00000001);
    chk("t5_reg3", r1, 32'h0000FFFF);

    // Reset at bit 10 of a write, then an ignored rreq during a read
    do_write(6'd6, 32'h0, 32'hFFFFFFFF, 6'd0, 32'h0, 32'h0, "t6pre", -1);
    do_write(6'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd0, 32'h0, 32'h0, "t6", 10);
    do_read(6'd6, 6'd5, r0, r1, "t6", 3);
    chk("t6_reg6", r0, 32'h000003FF);
    chk("t6_reg5", r1, 32'hDEADBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
